// File: rtl/fix_mul_pkg.sv
// Shared definitions for the fix_mul_arbiter slice: arbiter state encoding,
// default fixed-point format and the lane-id width helper.
package fix_mul_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } state_e;

  localparam int DEF_WIDTH       = 16;
  localparam int DEF_POINT_WIDTH = 8;

  function automatic int lane_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fix_mul_core.sv
// Registered signed WIDTH x WIDTH multiplier, MUL_LAT stages, full-width product.
// Each stage only loads when a beat occupies it, so the output holds between beats.
module fix_mul_core
  import fix_mul_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MUL_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [MUL_LAT-1:0]        stage_en,
  input  logic signed [WIDTH-1:0]   op_a,
  input  logic signed [WIDTH-1:0]   op_b,
  output logic signed [2*WIDTH-1:0] product
);

  logic signed [2*WIDTH-1:0] stage_q [MUL_LAT];
  logic signed [2*WIDTH-1:0] stage_d [MUL_LAT];

  always_comb begin
    for (int k = 0; k < MUL_LAT; k++) stage_d[k] = stage_q[k];
    if (stage_en[0]) stage_d[0] = op_a * op_b;
    for (int k = 1; k < MUL_LAT; k++) begin
      if (stage_en[k]) stage_d[k] = stage_q[k-1];
    end
  end

  // NOTE: datapath registers are reset too, so res_data reads 0 out of reset
  // instead of X; a handful of flops is cheap insurance for downstream lanes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < MUL_LAT; k++) stage_q[k] <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign product = stage_q[MUL_LAT-1];

endmodule

// File: rtl/fix_mul_arbiter.sv
// Round-robin, burst-locking arbiter in front of one shared fixed-point multiplier.
// Define FIX_MUL_SAT_EN to clamp results and flag overflow; otherwise results wrap.
module fix_mul_arbiter
  import fix_mul_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int WIDTH       = DEF_WIDTH,
  parameter int POINT_WIDTH = DEF_POINT_WIDTH,
  parameter int MUL_LAT     = 1,
  parameter int BURST_MAX   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ-1:0]       req_last,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic [N_REQ-1:0]       res_valid,
  output logic [WIDTH-1:0]       res_data,
  output logic                   res_ovf,
  output logic                   busy
);

  localparam int LW = lane_w(N_REQ);
  localparam int CW = $clog2(BURST_MAX + 1);

  function automatic logic [LW-1:0] lane_add(input logic [LW-1:0] base, input int off);
    return LW'((int'(base) + off) % N_REQ);
  endfunction

  state_e                   state_q, state_d;
  logic [LW-1:0]            ptr_q, ptr_d, owner_q, owner_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic signed [WIDTH-1:0]  op_a_q, op_a_d, op_b_q, op_b_d;
  logic [MUL_LAT:0]         tag_v_q, tag_v_d;
  logic [LW-1:0]            tag_id_q [MUL_LAT+1];
  logic [LW-1:0]            tag_id_d [MUL_LAT+1];

  logic [WIDTH-1:0]         lane_a [N_REQ];
  logic [WIDTH-1:0]         lane_b [N_REQ];
  logic                     grant_any, hs;
  logic [LW-1:0]            grant_id;

  // NOTE: every always_comb output gets a default on its first line, so no
  // path through the case/if tree can leave it unassigned and infer a latch.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      lane_a[i] = req_a[i*WIDTH +: WIDTH];
      lane_b[i] = req_b[i*WIDTH +: WIDTH];
    end
    if (state_q == LOCK) begin
      grant_any = req_valid[owner_q];
      grant_id  = owner_q;
    end else begin
      // Scan downward so the lane closest to the pointer is the last writer.
      for (int i = N_REQ - 1; i >= 0; i--) begin
        if (req_valid[lane_add(ptr_q, i)]) begin
          grant_any = 1'b1;
          grant_id  = lane_add(ptr_q, i);
        end
      end
    end
  end

  assign hs        = grant_any && !rst;
  assign req_ready = hs ? (N_REQ'(1) << grant_id) : '0;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    if (hs) begin
      case (state_q)
        ARB: begin
          if (req_last[grant_id] || BURST_MAX == 1) begin
            ptr_d = lane_add(grant_id, 1);
          end else begin
            state_d = LOCK;
            owner_d = grant_id;
            cnt_d   = CW'(1);
          end
        end
        LOCK: begin
          cnt_d = cnt_q + 1'b1;
          if (req_last[owner_q] || cnt_d == CW'(BURST_MAX)) begin
            state_d = ARB;
            ptr_d   = lane_add(owner_q, 1);
            cnt_d   = '0;
          end
        end
        default: state_d = ARB;
      endcase
    end
  end

  // Operand stage sits one cycle ahead of the core; tags shadow core stages.
  always_comb begin
    op_a_d     = hs ? lane_a[grant_id] : op_a_q;
    op_b_d     = hs ? lane_b[grant_id] : op_b_q;
    tag_v_d    = {tag_v_q[MUL_LAT-1:0], hs};
    tag_id_d   = tag_id_q;
    tag_id_d[0] = grant_id;
    for (int k = 1; k <= MUL_LAT; k++) tag_id_d[k] = tag_id_q[k-1];
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      tag_v_q <= '0;
      for (int k = 0; k <= MUL_LAT; k++) tag_id_q[k] <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      tag_v_q  <= tag_v_d;
      tag_id_q <= tag_id_d;
    end
  end

  logic signed [2*WIDTH-1:0] product, shifted;
  logic                      ovf;

  fix_mul_core #(
    .WIDTH   (WIDTH),
    .MUL_LAT (MUL_LAT)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .stage_en (tag_v_q[MUL_LAT-1:0]),
    .op_a     (op_a_q),
    .op_b     (op_b_q),
    .product  (product)
  );

  assign shifted = product >>> POINT_WIDTH;

`ifdef FIX_MUL_SAT_EN
  // In range exactly when the bits above the result sign all match it.
  always_comb begin
    ovf      = !((&shifted[2*WIDTH-1:WIDTH-1]) || !(|shifted[2*WIDTH-1:WIDTH-1]));
    res_data = shifted[WIDTH-1:0];
    if (ovf) res_data = shifted[2*WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                           : {1'b0, {(WIDTH-1){1'b1}}};
  end
`else
  logic shifted_hi_unused;
  assign shifted_hi_unused = ^shifted[2*WIDTH-1:WIDTH];
  assign ovf      = 1'b0;
  assign res_data = shifted[WIDTH-1:0];
`endif

  assign res_valid = tag_v_q[MUL_LAT] ? (N_REQ'(1) << tag_id_q[MUL_LAT]) : '0;
  assign res_ovf   = ovf && tag_v_q[MUL_LAT];
  assign busy      = (|tag_v_q) || (state_q == LOCK);

endmodule

// File: tb/tb_fix_mul_arbiter.sv
// Self-checking bench for fix_mul_arbiter: directed scenarios plus randomized
// lane bursts, compared cycle by cycle against a behavioural reference model.
module tb_fix_mul_arbiter;

  localparam int N   = 4;
  localparam int W   = 16;
  localparam int PW  = 8;
  localparam int LAT = 1;
  localparam int BM  = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0, req_last = '0;
  logic [N*W-1:0] req_a = '0, req_b = '0;
  logic [N-1:0]   req_ready, res_valid;
  logic [W-1:0]   res_data;
  logic           res_ovf, busy;

  always #5 clk = ~clk;

  fix_mul_arbiter #(
    .N_REQ(N), .WIDTH(W), .POINT_WIDTH(PW), .MUL_LAT(LAT), .BURST_MAX(BM)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_last(req_last),
    .req_a(req_a), .req_b(req_b), .req_ready(req_ready), .res_valid(res_valid),
    .res_data(res_data), .res_ovf(res_ovf), .busy(busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: arbitration rules and pending results keyed by due cycle.
  typedef struct {
    int         due;
    int         lane;
    logic [W-1:0] data;
    logic       ovf;
  } res_t;

  res_t         pend[$];
  int           grant_log[$];
  int           cyc = 0;
  int           ptr = 0, locked = 0, owner = 0, cnt = 0;
  logic [W-1:0] last_data = '0;

  // Lane programs: rem beats left; mode 0 = last on final beat, 1 = always last, 2 = never last.
  int           rem[N];
  int           mode[N];
  logic [W-1:0] la[N], lb[N];
  bit           rnd_data = 0, bubbles = 0;

  function automatic void ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] d, output logic o);
    longint sa, sb, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = (sa * sb) >>> PW;
`ifdef FIX_MUL_SAT_EN
    if (p > 32767)       begin d = 16'h7FFF; o = 1'b1; end
    else if (p < -32768) begin d = 16'h8000; o = 1'b1; end
    else                 begin d = p[W-1:0]; o = 1'b0; end
`else
    d = p[W-1:0];
    o = 1'b0;
`endif
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      if (rnd_data) begin
        la[i] = W'($urandom);
        lb[i] = W'($urandom);
      end
      req_valid[i]     = (rem[i] > 0) && !(bubbles && $urandom_range(0, 3) == 0);
      req_last[i]      = (mode[i] == 1) || (mode[i] == 0 && rem[i] == 1);
      req_a[i*W +: W]  = la[i];
      req_b[i*W +: W]  = lb[i];
    end
  endtask

  // One clock cycle: drive, check outputs against the model, advance the model.
  task automatic step();
    logic [N-1:0] exp_rv, exp_rdy;
    logic         exp_ovf, exp_busy, lst, o;
    logic [W-1:0] d;
    int           g;
    drive_inputs();
    #1;
    exp_busy = (locked != 0);
    foreach (pend[k]) if (pend[k].due <= cyc + LAT) exp_busy = 1'b1;
    exp_rv  = '0;
    exp_ovf = 1'b0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      exp_rv[pend[0].lane] = 1'b1;
      last_data = pend[0].data;
      exp_ovf   = pend[0].ovf;
      void'(pend.pop_front());
    end
    check("res_valid", res_valid, exp_rv);
    check("res_data", res_data, last_data);
    check("res_ovf", res_ovf, exp_ovf);
    check("busy", busy, exp_busy);

    g = -1;
    if (locked != 0) begin
      if (req_valid[owner]) g = owner;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (g < 0 && req_valid[(ptr + i) % N]) g = (ptr + i) % N;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("req_ready", req_ready, exp_rdy);

    if (g >= 0) begin
      grant_log.push_back(g);
      ref_mul(la[g], lb[g], d, o);
      pend.push_back('{cyc + 1 + LAT, g, d, o});
      rem[g]--;
      lst = req_last[g];
      if (locked == 0) begin
        if (lst || BM == 1) ptr = (g + 1) % N;
        else begin
          locked = 1;
          owner  = g;
          cnt    = 1;
        end
      end else begin
        cnt++;
        if (lst || cnt == BM) begin
          locked = 0;
          ptr    = (owner + 1) % N;
        end
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    req_last  = '0;
    for (int i = 0; i < N; i++) begin
      rem[i]  = 0;
      mode[i] = 0;
    end
    @(posedge clk);
    cyc++;
    #1;
    rst = 1'b0;
    ptr = 0; locked = 0; owner = 0; cnt = 0;
    pend.delete();
    last_data = '0;
    check("rst_res_valid", res_valid, '0);
    check("rst_res_data", res_data, '0);
    check("rst_res_ovf", res_ovf, 1'b0);
    check("rst_busy", busy, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < N; i++) rem[i] = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic single_beat(input int lane, input logic [W-1:0] a, input logic [W-1:0] b);
    la[lane]   = a;
    lb[lane]   = b;
    rem[lane]  = 1;
    mode[lane] = 0;
    step();
    step();
  endtask

  int exp_seq[$];

  initial begin
    for (int i = 0; i < N; i++) begin
      rem[i] = 0; mode[i] = 0; la[i] = '0; lb[i] = '0;
    end
    do_reset();

    // Single beat on lane 2: 1.5 * 2.0 = 3.0, result two cycles after handshake.
    single_beat(2, 16'h0180, 16'h0200);
    check("t1_res_valid", res_valid, 4'b0100);
    check("t1_res_data", res_data, 16'h0300);
    idle(2);

    // Negative operand: -1.0 * 2.5 = -2.5.
    single_beat(0, 16'hFF00, 16'h0280);
    check("t2_res_data", res_data, 16'hFD80);
    check("t2_res_ovf", res_ovf, 1'b0);
    idle(2);

    // Overflow: 127.0 * 127.0.
    single_beat(1, 16'h7F00, 16'h7F00);
`ifdef FIX_MUL_SAT_EN
    check("t5_res_data", res_data, 16'h7FFF);
    check("t5_res_ovf", res_ovf, 1'b1);
`else
    check("t5_res_data", res_data, 16'h0100);
    check("t5_res_ovf", res_ovf, 1'b0);
`endif
    idle(2);

    // Round-robin with every lane valid and single-beat bursts.
    do_reset();
    for (int i = 0; i < N; i++) begin
      rem[i] = 5; mode[i] = 1; la[i] = W'(16'h0100 * (i + 1)); lb[i] = 16'h0300;
    end
    grant_log.delete();
    for (int i = 0; i < 5; i++) step();
    exp_seq = '{0, 1, 2, 3, 0};
    foreach (exp_seq[i]) check($sformatf("t3_grant%0d", i), grant_log[i], exp_seq[i]);
    idle(4);

    // Burst lock: lane 1 three beats with lane 0 waiting, then lane 3 capped at BM.
    do_reset();
    rem[0] = 1; mode[0] = 0; la[0] = 16'h0040; lb[0] = 16'h0100;
    step();
    grant_log.delete();
    rem[1] = 3; mode[1] = 0; la[1] = 16'hFE80; lb[1] = 16'h0333;
    rem[0] = 1;
    for (int i = 0; i < 4; i++) step();
    exp_seq = '{1, 1, 1, 0};
    foreach (exp_seq[i]) check($sformatf("t4a_grant%0d", i), grant_log[i], exp_seq[i]);
    grant_log.delete();
    rem[3] = 8; mode[3] = 2; la[3] = 16'h1234; lb[3] = 16'hF00F;
    rem[0] = 2; mode[0] = 1;
    for (int i = 0; i < 6; i++) step();
    exp_seq = '{3, 3, 3, 3, 0, 3};
    foreach (exp_seq[i]) check($sformatf("t4b_grant%0d", i), grant_log[i], exp_seq[i]);
    idle(3);

    // Reset while locked with two beats in flight.
    do_reset();
    rem[3] = 8; mode[3] = 2;
    for (int i = 0; i < 3; i++) step();
    check("t6_busy_before", busy, 1'b1);
    do_reset();
    for (int i = 0; i < 3; i++) step();
    grant_log.delete();
    rem[2] = 1; rem[1] = 1; mode[1] = 0; mode[2] = 0;
    step();
    check("t6_first_grant", grant_log[0], 1);
    idle(3);

    // Randomized bursts, bubbles and operands.
    rnd_data = 1;
    bubbles  = 1;
    for (int c = 0; c < 600; c++) begin
      if (c == 300) do_reset();
      for (int i = 0; i < N; i++) begin
        if (rem[i] == 0 && $urandom_range(0, 2) == 0) begin
          mode[i] = $urandom_range(0, 2);
          rem[i]  = (mode[i] == 2) ? BM * $urandom_range(1, 2) : $urandom_range(1, 7);
        end
      end
      step();
    end
    bubbles = 0;
    for (int c = 0; c < 40; c++) step();
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
